otg_hpi_responder: RTL and testbench
====================================

# otg_hpi_responder

Device-side responder for the 16-bit OTG host-port interface (HPI) that the Nios II bit-bangs through its HPI data/address/control PIOs. It decodes the host's chip-select/read/write strobes and serves four HPI registers: DATA, MAILBOX, ADDRESS and STATUS. DATA accesses read and write an internal word RAM through an auto-incrementing address pointer. It stands in for the EZ-OTG device in simulation and on-chip loopback bring-up, so host USB driver code runs unchanged against it.

## Interface
- MEM_WORDS, 1024: internal RAM depth in 16-bit words, power of two.
- RAM_INIT_FILE, "": optional $readmemh image; empty means RAM is uninitialised.

- clk  in  1  system clock, same domain as the HPI PIOs.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- otg_cs_n  in  1  HPI chip select, active low.
- otg_rd_n  in  1  HPI read strobe, active low.
- otg_wr_n  in  1  HPI write strobe, active low.
- otg_rst_n  in  1  HPI device reset, active low; sampled on clk.
- otg_addr  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- otg_data_in  in  16  host-driven write data.
- otg_data_out  out  16  read data to host.
- otg_data_oe  out  1  high while the responder drives otg_data_out.
- otg_int  out  1  interrupt to host; high while the to-host mailbox is full.
- mbx_tx_data  in  16  device-side word for the to-host mailbox.
- mbx_tx_wr  in  1  one-cycle pulse that loads mbx_tx_data.
- mbx_rx_data  out  16  last word the host wrote to MAILBOX.
- mbx_rx_valid  out  1  high from a host MAILBOX write until mbx_rx_ack.
- mbx_rx_ack  in  1  one-cycle pulse that clears mbx_rx_valid.

## Operation
- Strobe qualification: rd_act = ~cs_n & ~rd_n & wr_n; wr_act = ~cs_n & ~wr_n & rd_n. If rd_n and wr_n are both low, the access is ignored and STATUS[15] (proto_err) is set. proto_err is sticky until reset.
- FSM states: IDLE, RD_FETCH, RD_HOLD, WR_HOLD, WR_COMMIT.
  - IDLE -> RD_FETCH when rd_act is first seen.
  - IDLE -> WR_HOLD when wr_act is first seen.
  - RD_FETCH -> RD_HOLD unconditionally.
  - RD_HOLD -> IDLE when rd_act drops. That cycle performs the read side effects.
  - WR_HOLD captures otg_data_in and otg_addr every cycle and moves to WR_COMMIT when wr_act drops.
  - WR_COMMIT performs the write and returns to IDLE.
- DATA (0):
  - Read returns RAM[addr_ptr[AW:1]], where AW = log2(MEM_WORDS). On read end, addr_ptr += 2.
  - Write stores the captured word at RAM[addr_ptr[AW:1]], then addr_ptr += 2.
  - addr_ptr is 16 bits and wraps 0xFFFE -> 0x0000. RAM indexing ignores addr_ptr bits above AW and bit 0, so the RAM aliases.
- MAILBOX (1):
  - Host write loads mbx_rx_data and sets mbx_rx_valid.
  - Host read returns the to-host word. On read end it clears mbx_tx_full, which drops otg_int.
- ADDRESS (2): a write loads addr_ptr with the captured word, bit 0 forced to 0. A read returns addr_ptr.
- STATUS (3): read-only; writes are ignored.
  - bit0: mbx_tx_full.
  - bit1: mbx_rx_valid.
  - bit15: proto_err.
  - All other bits read 0.
- mbx_tx_wr loads the to-host mailbox and sets mbx_tx_full. It overwrites any unread word, and mbx_tx_full stays set.
- Same-cycle mbx_tx_wr and host MAILBOX read end: the new word is kept and mbx_tx_full stays 1.
- Same-cycle host MAILBOX write commit and mbx_rx_ack: the write wins and mbx_rx_valid stays 1.
- otg_rst_n low acts exactly as reset, except that RAM is never cleared by either reset.
- Reset values of all outputs and registers:
  - otg_data_out = 0, otg_data_oe = 0, otg_int = 0.
  - mbx_rx_data = 0, mbx_rx_valid = 0.
  - addr_ptr = 0, mbx_tx_full = 0, proto_err = 0.
  - FSM = IDLE.
- Reset mid-access: the access is abandoned. No RAM write and no pointer increment occur.

## Timing
- Cycle numbering: cycle 0 is the first clk edge that samples rd_act or wr_act.
- Read:
  - otg_data_oe = 1 from cycle 1 until the cycle after rd_act is sampled low.
  - otg_data_out is valid from cycle 2.
  - The host must hold rd_act for at least 3 cycles.
- Write:
  - The last word sampled while wr_act is high is the word written.
  - Commit happens 1 cycle after wr_act is sampled low.
  - A new access may start in the cycle after the commit.
- Minimum strobe width is 2 cycles for a write and 3 for a read. Shorter strobes give undefined data but never deadlock the FSM.
- Single-ported RAM: at most one RAM access per cycle, made only in RD_FETCH or WR_COMMIT.

## Configuration
- OTG_HPI_RESP_SYNC_EN
  - Defined: otg_cs_n, otg_rd_n, otg_wr_n and otg_rst_n each pass through a 2-flop synchroniser. All Timing latencies increase by 2 cycles, and the minimum strobe widths are unchanged. Use this when the strobes come from off-chip.
  - Undefined: the strobes are sampled directly.

## Test plan
- Reset, then read STATUS -> 0x0000, otg_int = 0, otg_data_oe = 0 outside the access.
- Write ADDRESS 0x0100, then DATA 0x1234, 0x5678; write ADDRESS 0x0100, then read DATA twice -> 0x1234, 0x5678; final ADDRESS read -> 0x0104.
- Write ADDRESS 0xFFFE, then write DATA 0xAAAA -> ADDRESS read = 0x0000; with MEM_WORDS = 1024, a DATA read at 0x07FE -> 0xAAAA.
- Pulse mbx_tx_wr with 0xBEEF -> otg_int = 1 and STATUS = 0x0001; host MAILBOX read -> 0xBEEF, otg_int = 0 the cycle after the read ends.
- Host writes MAILBOX 0xC0DE -> mbx_rx_valid = 1 and mbx_rx_data = 0xC0DE; a mbx_rx_ack in the commit cycle leaves mbx_rx_valid = 1.
- Drive rd_n and wr_n low together -> no RAM change and STATUS[15] = 1; assert reset mid-write -> addr_ptr = 0 and the target RAM word is unchanged.

Source files
------------

// File: rtl/otg_hpi_responder.sv
// Device-side responder for the 16-bit OTG host-port interface: DATA, MAILBOX, ADDRESS, STATUS.
// Define OTG_HPI_RESP_SYNC_EN to pass otg_cs_n/rd_n/wr_n/rst_n through 2-flop synchronisers.
module otg_hpi_responder #(
    parameter int    MEM_WORDS     = 1024,
    parameter string RAM_INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        otg_cs_n,
    input  logic        otg_rd_n,
    input  logic        otg_wr_n,
    input  logic        otg_rst_n,
    input  logic [1:0]  otg_addr,
    input  logic [15:0] otg_data_in,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    output logic        otg_int,
    input  logic [15:0] mbx_tx_data,
    input  logic        mbx_tx_wr,
    output logic [15:0] mbx_rx_data,
    output logic        mbx_rx_valid,
    input  logic        mbx_rx_ack
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_MBX    = 2'd1;
    localparam logic [1:0] REG_ADDR   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_HOLD,
        WR_HOLD,
        WR_COMMIT
    } state_t;

    logic cs_n, rd_n, wr_n, rst_n_s;

`ifdef OTG_HPI_RESP_SYNC_EN
    logic [1:0] cs_sync_q, rd_sync_q, wr_sync_q, rstn_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= 2'b11;
            rd_sync_q   <= 2'b11;
            wr_sync_q   <= 2'b11;
            rstn_sync_q <= 2'b11;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], otg_cs_n};
            rd_sync_q   <= {rd_sync_q[0], otg_rd_n};
            wr_sync_q   <= {wr_sync_q[0], otg_wr_n};
            rstn_sync_q <= {rstn_sync_q[0], otg_rst_n};
        end
    end

    assign cs_n     = cs_sync_q[1];
    assign rd_n     = rd_sync_q[1];
    assign wr_n     = wr_sync_q[1];
    assign rst_n_s  = rstn_sync_q[1];
`else
    assign cs_n     = otg_cs_n;
    assign rd_n     = otg_rd_n;
    assign wr_n     = otg_wr_n;
    assign rst_n_s  = otg_rst_n;
`endif

    logic hpi_rst;
    logic rd_act, wr_act, both_act;

    assign hpi_rst  = reset | ~rst_n_s;
    assign rd_act   = ~cs_n & ~rd_n &  wr_n;
    assign wr_act   = ~cs_n & ~wr_n &  rd_n;
    assign both_act = ~cs_n & ~rd_n & ~wr_n;

    state_t      state_q, state_d;
    logic [1:0]  acc_addr_q, acc_addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] addr_ptr_q, addr_ptr_d;
    logic [15:0] data_out_q, data_out_d;
    logic        oe_q, oe_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        tx_full_q, tx_full_d;
    logic [15:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        proto_err_q, proto_err_d;
    logic [15:0] ram_rdata_q;
    logic [15:0] rd_mux;
    logic        rd_end, wr_commit;

    always_comb begin
        case (acc_addr_q)
            REG_DATA: rd_mux = ram_rdata_q;
            REG_MBX:  rd_mux = tx_data_q;
            REG_ADDR: rd_mux = addr_ptr_q;
            default:  rd_mux = {proto_err_q, 13'd0, rx_valid_q, tx_full_q};
        endcase
    end

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        acc_addr_d = acc_addr_q;
        wdata_d    = wdata_q;
        rd_end     = 1'b0;
        wr_commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_act) begin
                    state_d    = RD_FETCH;
                    acc_addr_d = otg_addr;
                end else if (wr_act) begin
                    state_d    = WR_HOLD;
                    acc_addr_d = otg_addr;
                    wdata_d    = otg_data_in;
                end
            end
            RD_FETCH: state_d = RD_HOLD;
            RD_HOLD: begin
                if (!rd_act) begin
                    state_d = IDLE;
                    rd_end  = 1'b1;
                end
            end
            WR_HOLD: begin
                if (wr_act) begin
                    acc_addr_d = otg_addr;
                    wdata_d    = otg_data_in;
                end else begin
                    state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                wr_commit = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_out_d  = (state_q == RD_HOLD) ? rd_mux : data_out_q;
        oe_d        = (state_q == RD_FETCH) || (state_q == RD_HOLD);
        proto_err_d = proto_err_q | both_act;

        addr_ptr_d = addr_ptr_q;
        if (rd_end && acc_addr_q == REG_DATA)
            addr_ptr_d = addr_ptr_q + 16'd2;
        if (wr_commit && acc_addr_q == REG_DATA)
            addr_ptr_d = addr_ptr_q + 16'd2;
        if (wr_commit && acc_addr_q == REG_ADDR)
            addr_ptr_d = {wdata_q[15:1], 1'b0};

        // A device-side load beats a same-cycle host read end: the new word stays pending.
        tx_data_d = tx_data_q;
        tx_full_d = tx_full_q;
        if (mbx_tx_wr) begin
            tx_data_d = mbx_tx_data;
            tx_full_d = 1'b1;
        end else if (rd_end && acc_addr_q == REG_MBX) begin
            tx_full_d = 1'b0;
        end

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (wr_commit && acc_addr_q == REG_MBX) begin
            rx_data_d  = wdata_q;
            rx_valid_d = 1'b1;
        end else if (mbx_rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (hpi_rst) begin
            state_q     <= IDLE;
            acc_addr_q  <= REG_DATA;
            wdata_q     <= 16'd0;
            addr_ptr_q  <= 16'd0;
            data_out_q  <= 16'd0;
            oe_q        <= 1'b0;
            tx_data_q   <= 16'd0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= 16'd0;
            rx_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_addr_q  <= acc_addr_d;
            wdata_q     <= wdata_d;
            addr_ptr_q  <= addr_ptr_d;
            data_out_q  <= data_out_d;
            oe_q        <= oe_d;
            tx_data_q   <= tx_data_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    logic [15:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_we, ram_re;

    assign ram_idx = addr_ptr_q[AW:1];
    assign ram_we  = wr_commit && (acc_addr_q == REG_DATA) && !hpi_rst;
    assign ram_re  = (state_q == RD_FETCH);

    // NOTE: the RAM has no reset so it maps onto block memory; contents survive both resets.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem_q[ram_idx] <= wdata_q;
        if (ram_re)
            ram_rdata_q <= mem_q[ram_idx];
    end

    assign otg_data_out = data_out_q;
    assign otg_data_oe  = oe_q;
    assign otg_int      = tx_full_q;
    assign mbx_rx_data  = rx_data_q;
    assign mbx_rx_valid = rx_valid_q;

endmodule

// File: tb/tb_otg_hpi_responder.sv
// Self-checking bench for otg_hpi_responder: directed scenarios plus randomized host traffic
// compared against a register/array-level behavioural model.
module tb_otg_hpi_responder;

    localparam int MEMW = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        otg_cs_n = 1'b1, otg_rd_n = 1'b1, otg_wr_n = 1'b1, otg_rst_n = 1'b1;
    logic [1:0]  otg_addr = 2'd0;
    logic [15:0] otg_data_in = 16'd0;
    logic [15:0] otg_data_out;
    logic        otg_data_oe, otg_int;
    logic [15:0] mbx_tx_data = 16'd0;
    logic        mbx_tx_wr = 1'b0;
    logic [15:0] mbx_rx_data;
    logic        mbx_rx_valid;
    logic        mbx_rx_ack = 1'b0;

    always #5 clk = ~clk;

    otg_hpi_responder #(.MEM_WORDS(MEMW), .RAM_INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n), .otg_rst_n(otg_rst_n),
        .otg_addr(otg_addr), .otg_data_in(otg_data_in),
        .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe), .otg_int(otg_int),
        .mbx_tx_data(mbx_tx_data), .mbx_tx_wr(mbx_tx_wr),
        .mbx_rx_data(mbx_rx_data), .mbx_rx_valid(mbx_rx_valid), .mbx_rx_ack(mbx_rx_ack)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: a word array addressed by (pointer / 2) mod depth, plus mailbox flags.
    logic [15:0] m_mem [MEMW];
    bit          m_known [MEMW];
    logic [15:0] m_ptr, m_tx, m_rx;
    bit          m_tx_full, m_tx_known, m_rx_valid, m_perr;

    function automatic int m_idx();
        return (int'(m_ptr) / 2) % MEMW;
    endfunction

    function automatic logic [15:0] m_status();
        return (m_perr ? 16'h8000 : 16'h0) + (m_rx_valid ? 16'h2 : 16'h0) + (m_tx_full ? 16'h1 : 16'h0);
    endfunction

    task automatic m_reset();
        m_ptr = 16'd0; m_tx_full = 0; m_tx_known = 0; m_rx = 16'd0; m_rx_valid = 0; m_perr = 0;
    endtask

    task automatic m_host_write(input logic [1:0] a, input logic [15:0] d);
        case (a)
            2'd0: begin m_mem[m_idx()] = d; m_known[m_idx()] = 1; m_ptr = m_ptr + 16'd2; end
            2'd1: begin m_rx = d; m_rx_valid = 1; end
            2'd2: m_ptr = d & 16'hFFFE;
            default: ;
        endcase
    endtask

    task automatic m_host_read(input logic [1:0] a, output logic [15:0] v, output bit known);
        known = 1;
        case (a)
            2'd0: begin v = m_mem[m_idx()]; known = m_known[m_idx()]; m_ptr = m_ptr + 16'd2; end
            2'd1: begin v = m_tx; known = m_tx_known; m_tx_full = 0; end
            2'd2: v = m_ptr;
            default: v = m_status();
        endcase
    endtask

    task automatic hpi_write(input logic [1:0] a, input logic [15:0] d, input int width, input bit ack_commit);
        @(negedge clk);
        otg_cs_n = 1'b0; otg_wr_n = 1'b0; otg_addr = a;
        for (int i = 0; i < width; i++) begin
            otg_data_in = (i == width - 1) ? d : 16'($urandom);
            @(negedge clk);
        end
        otg_cs_n = 1'b1; otg_wr_n = 1'b1; otg_data_in = 16'($urandom);
        @(negedge clk);
        if (ack_commit) mbx_rx_ack = 1'b1;
        @(negedge clk);
        mbx_rx_ack = 1'b0;
    endtask

    task automatic hpi_read(input logic [1:0] a, input int width, input bit tx_at_end, input logic [15:0] tx_d,
                            output logic [15:0] data, output logic [2:0] oe_seq, output logic int_after);
        bit oe_ok;
        oe_ok = 1;
        @(negedge clk);
        otg_cs_n = 1'b0; otg_rd_n = 1'b0; otg_addr = a;
        for (int i = 0; i < width; i++) begin
            @(negedge clk);
            if (i == 0 && otg_data_oe !== 1'b0) oe_ok = 0;
            if (i >= 1 && otg_data_oe !== 1'b1) oe_ok = 0;
        end
        data = otg_data_out;
        otg_cs_n = 1'b1; otg_rd_n = 1'b1;
        if (tx_at_end) begin mbx_tx_wr = 1'b1; mbx_tx_data = tx_d; end
        @(negedge clk);
        mbx_tx_wr = 1'b0;
        oe_seq[2] = oe_ok;
        oe_seq[1] = otg_data_oe;
        int_after = otg_int;
        @(negedge clk);
        oe_seq[0] = otg_data_oe;
    endtask

    task automatic tx_pulse(input logic [15:0] d);
        @(negedge clk);
        mbx_tx_wr = 1'b1; mbx_tx_data = d;
        @(negedge clk);
        mbx_tx_wr = 1'b0;
        m_tx = d; m_tx_full = 1; m_tx_known = 1;
    endtask

    // Host write plus model update in one step.
    task automatic do_write(input logic [1:0] a, input logic [15:0] d);
        hpi_write(a, d, 2, 1'b0);
        m_host_write(a, d);
    endtask

    // Host read compared against the model; name labels the FAIL line.
    task automatic do_read(input string name, input logic [1:0] a, input int width);
        logic [15:0] got, exp;
        logic [2:0]  oe_seq;
        logic        int_after;
        bit          known;
        hpi_read(a, width, 1'b0, 16'd0, got, oe_seq, int_after);
        m_host_read(a, exp, known);
        if (known) begin
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: read %h, expected %h", name, got, exp);
            end
        end
        checks++;
        if (oe_seq !== 3'b110) begin
            errors++;
            $display("FAIL %s_oe: oe pattern %b, expected 110", name, oe_seq);
        end
        checks++;
        if (int_after !== m_tx_full) begin
            errors++;
            $display("FAIL %s_int: otg_int %b, expected %b", name, int_after, m_tx_full);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
        checks++;
        if ({otg_data_out, otg_data_oe, otg_int, mbx_rx_data, mbx_rx_valid} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: out=%h oe=%b int=%b rx=%h rxv=%b, expected all 0",
                     otg_data_out, otg_data_oe, otg_int, mbx_rx_data, mbx_rx_valid);
        end
        do_read("reset_status", 2'd3, 3);
        do_read("reset_addr", 2'd2, 3);
    endtask

    task automatic test_data_seq();
        do_write(2'd2, 16'h0100);
        do_write(2'd0, 16'h1234);
        do_write(2'd0, 16'h5678);
        do_write(2'd2, 16'h0100);
        do_read("seq_rd0", 2'd0, 3);
        do_read("seq_rd1", 2'd0, 4);
        do_read("seq_addr", 2'd2, 3);
    endtask

    task automatic test_wrap();
        do_write(2'd2, 16'hFFFE);
        do_write(2'd0, 16'hAAAA);
        do_read("wrap_addr", 2'd2, 3);
        do_write(2'd2, 16'h07FF);
        do_read("alias_data", 2'd0, 3);
    endtask

    task automatic test_mailbox();
        tx_pulse(16'hBEEF);
        checks++;
        if (otg_int !== 1'b1) begin
            errors++;
            $display("FAIL mbx_int_set: otg_int %b, expected 1", otg_int);
        end
        do_read("mbx_status", 2'd3, 3);
        do_read("mbx_read", 2'd1, 3);
    endtask

    task automatic test_rx();
        hpi_write(2'd1, 16'hC0DE, 3, 1'b1);
        m_host_write(2'd1, 16'hC0DE);
        checks++;
        if (mbx_rx_valid !== m_rx_valid || mbx_rx_data !== m_rx) begin
            errors++;
            $display("FAIL rx_ack_collide: valid=%b data=%h, expected valid=%b data=%h",
                     mbx_rx_valid, mbx_rx_data, m_rx_valid, m_rx);
        end
        do_read("rx_status", 2'd3, 3);
        @(negedge clk); mbx_rx_ack = 1'b1;
        @(negedge clk); mbx_rx_ack = 1'b0;
        m_rx_valid = 0;
        checks++;
        if (mbx_rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_ack_clear: valid=%b, expected 0", mbx_rx_valid);
        end
    endtask

    task automatic test_back_to_back_tx();
        logic [15:0] got, exp;
        logic [2:0]  oe_seq;
        logic        int_after;
        bit          known;
        tx_pulse(16'h1111);
        hpi_read(2'd1, 3, 1'b1, 16'h2222, got, oe_seq, int_after);
        m_host_read(2'd1, exp, known);
        m_tx = 16'h2222; m_tx_full = 1;
        checks++;
        if (got !== exp || int_after !== m_tx_full) begin
            errors++;
            $display("FAIL tx_collide: data=%h int=%b, expected data=%h int=%b", got, int_after, exp, m_tx_full);
        end
        do_read("tx_collide_new", 2'd1, 3);
    endtask

    task automatic test_proto();
        do_write(2'd2, 16'h0200);
        do_write(2'd0, 16'h3C3C);
        do_write(2'd2, 16'h0200);
        @(negedge clk);
        otg_cs_n = 1'b0; otg_rd_n = 1'b0; otg_wr_n = 1'b0; otg_addr = 2'd0; otg_data_in = 16'hDEAD;
        repeat (3) @(negedge clk);
        otg_cs_n = 1'b1; otg_rd_n = 1'b1; otg_wr_n = 1'b1;
        m_perr = 1;
        repeat (2) @(negedge clk);
        do_read("proto_status", 2'd3, 3);
        do_read("proto_addr", 2'd2, 3);
        do_read("proto_data", 2'd0, 3);
    endtask

    task automatic test_reset_mid_write();
        do_write(2'd2, 16'h0040);
        do_write(2'd0, 16'h1111);
        do_write(2'd2, 16'h0040);
        @(negedge clk);
        otg_cs_n = 1'b0; otg_wr_n = 1'b0; otg_addr = 2'd0; otg_data_in = 16'h2222;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; otg_cs_n = 1'b1; otg_wr_n = 1'b1;
        m_reset();
        repeat (2) @(negedge clk);
        do_read("midrst_addr", 2'd2, 3);
        do_read("midrst_status", 2'd3, 3);
        do_write(2'd2, 16'h0040);
        do_read("midrst_data", 2'd0, 3);
    endtask

    task automatic test_otg_rst();
        tx_pulse(16'h5555);
        do_write(2'd1, 16'h7777);
        @(negedge clk); otg_rst_n = 1'b0;
        @(negedge clk); otg_rst_n = 1'b1;
        m_reset();
        checks++;
        if (otg_int !== 1'b0 || mbx_rx_valid !== 1'b0 || mbx_rx_data !== 16'd0) begin
            errors++;
            $display("FAIL otg_rst_outputs: int=%b rxv=%b rx=%h, expected 0 0 0000", otg_int, mbx_rx_valid, mbx_rx_data);
        end
        do_read("otg_rst_status", 2'd3, 3);
        do_write(2'd2, 16'h0040);
        do_read("otg_rst_ram", 2'd0, 3);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: do_write(2'd2, 16'($urandom) & 16'h00FF | 16'h0300);
                1: begin
                    logic [15:0] d;
                    d = 16'($urandom);
                    hpi_write(2'd0, d, int'($urandom_range(2, 4)), 1'b0);
                    m_host_write(2'd0, d);
                end
                2: do_read("rnd_data", 2'd0, int'($urandom_range(3, 5)));
                3: do_read("rnd_addr", 2'd2, int'($urandom_range(3, 5)));
                4: begin
                    tx_pulse(16'($urandom));
                    do_read("rnd_tx_status", 2'd3, 3);
                end
                5: do_read("rnd_mbx", 2'd1, int'($urandom_range(3, 5)));
                default: do_read("rnd_status", 2'd3, 3);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_data_seq();
        test_wrap();
        test_mailbox();
        test_rx();
        test_back_to_back_tx();
        test_proto();
        test_reset_mid_write();
        test_otg_rst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
